// File: rtl/mem_access_stage.sv
// EX/MEM pipeline stage: latches execute results and performs byte/half/word
// loads and stores over a req/ack data bus, stalling upstream while busy.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  alu_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] result_i,
    input  logic        wrn_i,
    input  logic [4:0]  wrAddr_i,
    output logic        stall_o,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        out_valid,
    output logic        wrn_o,
    output logic [4:0]  wrAddr_o,
    output logic [31:0] wrData_o,
    output logic        align_err,
    output logic        bus_err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    // Memory op codes on the ALU op bus (MIPS primary opcodes)
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t       r_state;
    logic [CW-1:0] r_cnt;
    logic         r_req, r_we, r_out_valid, r_wrn, r_align_err, r_bus_err;
    logic [31:0]  r_addr, r_wdata, r_wr_data;
    logic [3:0]   r_be;
    logic [4:0]   r_wr_addr;
    logic         r_ld, r_sext, r_wrn_l;
    logic [1:0]   r_size, r_lane;
    logic [4:0]   r_wa_l;

    logic         w_is_mem, w_is_ld, w_sext, w_misalign;
    logic [1:0]   w_size;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata, w_ld_data;
    logic [7:0]   w_byte;
    logic [15:0]  w_half;

    // Decode of the incoming execute bundle
    always_comb begin
        w_is_mem = 1'b1;
        w_is_ld  = 1'b1;
        w_sext   = 1'b0;
        w_size   = SZ_W;
        case (alu_op_i)
            OP_LB:   begin w_size = SZ_B; w_sext = 1'b1; end
            OP_LBU:  w_size = SZ_B;
            OP_LH:   begin w_size = SZ_H; w_sext = 1'b1; end
            OP_LHU:  w_size = SZ_H;
            OP_LW:   w_size = SZ_W;
            OP_SB:   begin w_size = SZ_B; w_is_ld = 1'b0; end
            OP_SH:   begin w_size = SZ_H; w_is_ld = 1'b0; end
            OP_SW:   begin w_size = SZ_W; w_is_ld = 1'b0; end
            default: begin w_is_mem = 1'b0; w_is_ld = 1'b0; end
        endcase

        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = mem_data_i;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b1000 >> mem_addr_i[1:0];
                w_wdata = {4{mem_data_i[7:0]}};
            end
            SZ_H: begin
                w_misalign = mem_addr_i[0];
                w_be       = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata    = {2{mem_data_i[15:0]}};
            end
            default: w_misalign = |mem_addr_i[1:0];
        endcase
    end

    // Big-endian lane extraction of the returned word
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[31:24];
            2'd1:    w_byte = dmem_rdata[23:16];
            2'd2:    w_byte = dmem_rdata[15:8];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = r_lane[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (r_size)
            SZ_B:    w_ld_data = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_H:    w_ld_data = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
            r_wrn       <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            r_ld        <= 1'b0;
            r_sext      <= 1'b0;
            r_size      <= '0;
            r_lane      <= '0;
            r_wrn_l     <= 1'b0;
            r_wa_l      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_align_err <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (!w_is_mem) begin
                            r_out_valid <= 1'b1;
                            r_wrn       <= wrn_i;
                            r_wr_addr   <= wrAddr_i;
                            r_wr_data   <= result_i;
                        end else if (w_misalign) begin
                            r_out_valid <= 1'b1;
                            r_wrn       <= 1'b0;
                            r_wr_addr   <= wrAddr_i;
                            r_wr_data   <= '0;
                            r_align_err <= 1'b1;
                        end else begin
                            r_state <= ACCESS;
                            r_cnt   <= '0;
                            r_req   <= 1'b1;
                            r_we    <= ~w_is_ld;
                            r_addr  <= {mem_addr_i[31:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_ld    <= w_is_ld;
                            r_sext  <= w_sext;
                            r_size  <= w_size;
                            r_lane  <= mem_addr_i[1:0];
                            r_wrn_l <= wrn_i;
                            r_wa_l  <= wrAddr_i;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        r_state     <= IDLE;
                        r_req       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_wr_addr   <= r_wa_l;
                        r_wrn       <= r_ld & r_wrn_l;
                        r_wr_data   <= r_ld ? w_ld_data : 32'd0;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state     <= IDLE;
                        r_req       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_wr_addr   <= r_wa_l;
                        r_wrn       <= 1'b0;
                        r_wr_data   <= '0;
                        r_bus_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall_o    = (r_state == ACCESS);
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;
    assign out_valid  = r_out_valid;
    assign wrn_o      = r_wrn;
    assign wrAddr_o   = r_wr_addr;
    assign wrData_o   = r_wr_data;
    assign align_err  = r_align_err;
    assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writeback
// bundles, a negedge monitor pops and compares whenever out_valid is seen.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 16;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LH  = 8'h21;
    localparam logic [7:0] OP_LW  = 8'h23;
    localparam logic [7:0] OP_LBU = 8'h24;
    localparam logic [7:0] OP_LHU = 8'h25;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2B;
    localparam logic [7:0] OP_ADD = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  alu_op_i = '0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0, result_i = '0;
    logic        wrn_i = 1'b0;
    logic [4:0]  wrAddr_i = '0;
    logic        stall_o, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        out_valid, wrn_o, align_err, bus_err;
    logic [4:0]  wrAddr_o;
    logic [31:0] wrData_o;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op_i(alu_op_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .result_i(result_i),
        .wrn_i(wrn_i), .wrAddr_i(wrAddr_i), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .out_valid(out_valid), .wrn_o(wrn_o),
        .wrAddr_o(wrAddr_o), .wrData_o(wrData_o), .align_err(align_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wrn;
        logic [4:0]  wa;
        logic [31:0] data;
        bit          chk_wa;
        bit          chk_data;
        logic        align;
        logic        buserr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: behaviour stated in terms of byte offsets and sizes
    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_load(input logic [7:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW);
    endfunction

    function automatic logic [3:0] exp_be(input logic [7:0] op, input logic [31:0] addr);
        int idx = int'(addr % 4);
        int sz = op_size(op);
        if (sz == 1) return 4'(1 << (3 - idx));
        if (sz == 2) return (idx < 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] d);
        int sz = op_size(op);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int idx = int'(addr % 4);
        logic [31:0] v;
        case (op_size(op))
            1: begin
                v = (rd >> (8 * (3 - idx))) & 32'hFF;
                if (op == OP_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2: begin
                v = (rd >> (16 * (1 - idx / 2))) & 32'hFFFF;
                if (op == OP_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Monitor: every out_valid must match the oldest expected bundle
    exp_t m_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("wrn_o", 32'(wrn_o), 32'(m_e.wrn));
                    if (m_e.chk_wa)   chk("wrAddr_o", 32'(wrAddr_o), 32'(m_e.wa));
                    if (m_e.chk_data) chk("wrData_o", wrData_o, m_e.data);
                    chk("align_err", 32'(align_err), 32'(m_e.align));
                    chk("bus_err", 32'(bus_err), 32'(m_e.buserr));
                end
            end else if (align_err || bus_err) begin
                chk("err_without_valid", 32'(align_err | bus_err), 32'd0);
            end
        end
    end

    task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] res, input logic wrn, input logic [4:0] wa,
                         input int delay, input bit noack, input logic [31:0] rdata);
        int   n;
        int   sz;
        bit   mis;
        exp_t e;
        n = 0;
        while (stall_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (stall_o) chk("stall_release", 32'(stall_o), 32'd0);
        sz  = op_size(op);
        mis = (sz != 0) && ((addr % sz) != 0);
        e.wa = wa; e.chk_wa = 1; e.chk_data = 1; e.align = 0; e.buserr = 0;
        if (sz == 0) begin
            e.wrn = wrn; e.data = res;
        end else if (mis) begin
            e.wrn = 0; e.data = 0; e.chk_wa = 0; e.align = 1;
        end else if (noack) begin
            e.wrn = 0; e.data = 0; e.chk_wa = 0; e.chk_data = 0; e.buserr = 1;
        end else if (is_load(op)) begin
            e.wrn = wrn; e.data = exp_load(op, addr, rdata);
        end else begin
            e.wrn = 0; e.data = 0;
        end
        q.push_back(e);
        in_valid = 1; alu_op_i = op; mem_addr_i = addr; mem_data_i = sdata;
        result_i = res; wrn_i = wrn; wrAddr_i = wa; dmem_rdata = rdata;
        @(posedge clk); #1;
        in_valid = 0;
        if (sz == 0 || mis) begin
            chk("latency1_valid", 32'(out_valid), 32'd1);
            chk("no_req", 32'(dmem_req), 32'd0);
            chk("no_stall", 32'(stall_o), 32'd0);
        end else begin
            chk("req", 32'(dmem_req), 32'd1);
            chk("stall", 32'(stall_o), 32'd1);
            chk("we", 32'(dmem_we), 32'(!is_load(op)));
            chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("be", 32'(dmem_be), 32'(exp_be(op, addr)));
            if (!is_load(op)) chk("wdata", dmem_wdata, exp_wdata(op, sdata));
            if (noack) begin
                n = 0;
                while (dmem_req && n < 40) begin
                    n++;
                    @(posedge clk); #1;
                end
                chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
                chk("timeout_stall", 32'(stall_o), 32'd0);
            end else begin
                repeat (delay) begin
                    @(posedge clk); #1;
                    chk("hold_req", 32'(dmem_req), 32'd1);
                    chk("hold_be", 32'(dmem_be), 32'(exp_be(op, addr)));
                    chk("hold_stall", 32'(stall_o), 32'd1);
                end
                dmem_ack = 1;
                @(posedge clk); #1;
                dmem_ack = 0;
                chk("ack_req_drop", 32'(dmem_req), 32'd0);
                chk("ack_stall_drop", 32'(stall_o), 32'd0);
                chk("ack_valid", 32'(out_valid), 32'd1);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [7:0]  ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    logic [7:0]  r_op;
    logic [31:0] r_addr;
    int          sz;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_wrData", wrData_o, 32'd0);
        chk("rst_wrn", 32'(wrn_o), 32'd0);
        rst = 0;

        do_op(OP_ADD, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd3, 0, 0, 32'h0);
        do_op(OP_LB,  32'h101, 32'h0, 32'h0, 1'b1, 5'd7, 1, 0, 32'h11F2_3344);
        do_op(OP_LBU, 32'h101, 32'h0, 32'h0, 1'b1, 5'd8, 1, 0, 32'h11F2_3344);
        do_op(OP_SH,  32'h102, 32'hAAAA_BEEF, 32'h0, 1'b1, 5'd9, 0, 0, 32'h0);
        do_op(OP_LW,  32'h103, 32'h0, 32'h0, 1'b1, 5'd10, 0, 0, 32'h0);
        do_op(OP_LH,  32'h102, 32'h0, 32'h0, 1'b1, 5'd11, 0, 0, 32'h1234_8001);
        do_op(OP_LW,  32'h200, 32'h0, 32'h0, 1'b1, 5'd12, 0, 1, 32'h0);
        do_op(OP_ADD, 32'h0, 32'h0, 32'hCAFE_0001, 1'b1, 5'd13, 0, 0, 32'h0);

        // Reset while an access is outstanding; a late ack must be ignored
        in_valid = 1; alu_op_i = OP_LW; mem_addr_i = 32'h300; wrn_i = 1; wrAddr_i = 5'd4;
        @(posedge clk); #1;
        in_valid = 0;
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall_o), 32'd0);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        rst = 0;
        dmem_ack = 1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("late_ack_no_valid", 32'(out_valid), 32'd0);
        end
        dmem_ack = 0;

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 8) r_op = ops[$urandom_range(0, 7)];
            else r_op = 8'($urandom_range(0, 15));
            r_addr = $urandom;
            sz = op_size(r_op);
            if (sz > 1 && $urandom_range(0, 3) != 0) r_addr = r_addr - (r_addr % sz);
            do_op(r_op, r_addr, $urandom, $urandom, 1'($urandom), 5'($urandom),
                  $urandom_range(0, 4), 0, $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
